// File: rtl/dac_pkg.sv
// Shared FSM state encoding and default timing constants for the DAC7611
// request scheduler.
package dac_pkg;

    localparam int DEF_DATA_W  = 12;
    localparam int DEF_HOLDOFF = 50;
    localparam int DEF_CLR_CYC = 4;
    localparam int DEF_BUSY_TO = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_HOLDOFF,
        ST_CLEAR
    } state_t;

    // Counter width for a count of n cycles (0 .. n-1), never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dac_scheduler.sv
// Two-requester round-robin scheduler in front of a DAC7611 serializer:
// grants samples, issues clear pulses, and enforces an idle holdoff between transactions.
module dac_scheduler
    import dac_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int CLR_CYC = DEF_CLR_CYC,
    parameter int BUSY_TO = DEF_BUSY_TO
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              ack0,
    output logic              ack1,
    input  logic              clr_req,
    output logic              clr_ack,
    output logic              dac_start,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_clr,
    input  logic              dac_busy,
    output logic              owner,
    output logic              err
);

    localparam int BUSY_W = cnt_w(BUSY_TO);
    localparam int HOLD_W = cnt_w(HOLDOFF);
    localparam int CLR_W  = cnt_w(CLR_CYC);

    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_TO - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLR_CYC - 1);

    state_t              state_reg, state_next;
    logic                ack0_reg, ack0_next;
    logic                ack1_reg, ack1_next;
    logic                clr_ack_reg, clr_ack_next;
    logic                start_reg, start_next;
    logic                dac_clr_reg, dac_clr_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                owner_reg, owner_next;
    logic                err_reg, err_next;
    logic [BUSY_W-1:0]   busy_cnt_reg, busy_cnt_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [CLR_W-1:0]    clr_cnt_reg, clr_cnt_next;
    logic                grant;

    // On a tie the requester that was not served last wins; otherwise whoever asks.
    assign grant = (req0 && req1) ? ~owner_reg : req1;

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ack0_reg     <= 1'b0;
            ack1_reg     <= 1'b0;
            clr_ack_reg  <= 1'b0;
            start_reg    <= 1'b0;
            dac_clr_reg  <= 1'b0;
            data_reg     <= '0;
            owner_reg    <= 1'b1;
            err_reg      <= 1'b0;
            busy_cnt_reg <= '0;
            hold_cnt_reg <= '0;
            clr_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ack0_reg     <= ack0_next;
            ack1_reg     <= ack1_next;
            clr_ack_reg  <= clr_ack_next;
            start_reg    <= start_next;
            dac_clr_reg  <= dac_clr_next;
            data_reg     <= data_next;
            owner_reg    <= owner_next;
            err_reg      <= err_next;
            busy_cnt_reg <= busy_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            clr_cnt_reg  <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ack0_next     = 1'b0;
        ack1_next     = 1'b0;
        clr_ack_next  = 1'b0;
        start_next    = 1'b0;
        dac_clr_next  = dac_clr_reg;
        data_next     = data_reg;
        owner_next    = owner_reg;
        err_next      = err_reg;
        busy_cnt_next = busy_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        clr_cnt_next  = clr_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next   = ST_CLEAR;
                    dac_clr_next = 1'b1;
                    clr_cnt_next = '0;
                end else if (req0 || req1) begin
                    state_next    = ST_WAIT_BUSY;
                    start_next    = 1'b1;
                    ack0_next     = ~grant;
                    ack1_next     = grant;
                    owner_next    = grant;
                    data_next     = grant ? data1 : data0;
                    busy_cnt_next = '0;
                end
            end

            ST_WAIT_BUSY: begin
                if (dac_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (busy_cnt_reg == BUSY_LAST) begin
                    err_next      = 1'b1;
                    state_next    = ST_HOLDOFF;
                    hold_cnt_next = '0;
                end else begin
                    busy_cnt_next = busy_cnt_reg + BUSY_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!dac_busy) begin
                    state_next    = ST_HOLDOFF;
                    hold_cnt_next = '0;
                end
            end

            ST_HOLDOFF: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end

            ST_CLEAR: begin
                // dac_clr drops and clr_ack pulses on the same edge that starts the holdoff.
                if (clr_cnt_reg == CLR_LAST) begin
                    dac_clr_next  = 1'b0;
                    clr_ack_next  = 1'b1;
                    state_next    = ST_HOLDOFF;
                    hold_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + CLR_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ack0      = ack0_reg;
    assign ack1      = ack1_reg;
    assign clr_ack   = clr_ack_reg;
    assign dac_start = start_reg;
    assign dac_clr   = dac_clr_reg;
    assign dac_data  = data_reg;
    assign owner     = owner_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_dac_scheduler.sv
// Directed bench for dac_scheduler: a cycle-timestamp model checks every output each
// cycle, and literal timing checks pin the model to hand-computed expectations.
module tb_dac_scheduler;

    localparam int HOLD = 50;
    localparam int CLRC = 4;
    localparam int BTO  = 8;

    logic        clk_50M = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [11:0] data0 = '0, data1 = '0;
    logic        clr_req = 1'b0;
    logic        dac_busy = 1'b0;
    logic        ack0, ack1, clr_ack, dac_start, dac_clr, owner, err;
    logic [11:0] dac_data;

    dac_scheduler dut (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .ack0      (ack0),
        .ack1      (ack1),
        .clr_req   (clr_req),
        .clr_ack   (clr_ack),
        .dac_start (dac_start),
        .dac_data  (dac_data),
        .dac_clr   (dac_clr),
        .dac_busy  (dac_busy),
        .owner     (owner),
        .err       (err)
    );

    always #5 clk_50M = ~clk_50M;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    // Serializer stand-in: busy rises 2 cycles after dac_start and lasts 16 cycles.
    bit busy_mode = 1'b1;
    int busy_rise = -1000;
    always @(posedge clk_50M) begin
        #1;
        if (busy_mode && dac_start) busy_rise = cyc + 2;
        dac_busy = busy_mode && (cyc >= busy_rise) && (cyc < busy_rise + 16);
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
        end
    endtask

    // Model: every expected output event is a cycle timestamp.
    bit          model_on = 1'b0;
    int          ack0_at, ack1_at, start_at, clr_ack_at, clr_from, clr_to, err_from;
    int          free_at, start_cyc, rise_cyc, data_apply, owner_apply;
    bit          pend;
    logic [11:0] data_pend, data_cur;
    logic        owner_pend, owner_cur, owner_latest;
    logic        g;

    task automatic model_reset();
        ack0_at = -1; ack1_at = -1; start_at = -1; clr_ack_at = -1;
        clr_from = -1; clr_to = -2; err_from = -1;
        data_pend = '0;  data_apply = cyc + 1;
        owner_pend = 1'b1; owner_apply = cyc + 1; owner_latest = 1'b1;
        pend = 1'b0; rise_cyc = -1; start_cyc = -1;
        free_at = cyc + 1;
    endtask

    always @(negedge clk_50M) begin
        if (!model_on) begin
            if (rst) begin
                model_on = 1'b1;
                model_reset();
            end
        end else begin
            if (cyc == data_apply)  data_cur  = data_pend;
            if (cyc == owner_apply) owner_cur = owner_pend;
            chk("ack0",      int'(ack0),      int'(cyc == ack0_at));
            chk("ack1",      int'(ack1),      int'(cyc == ack1_at));
            chk("dac_start", int'(dac_start), int'(cyc == start_at));
            chk("clr_ack",   int'(clr_ack),   int'(cyc == clr_ack_at));
            chk("dac_clr",   int'(dac_clr),   int'(cyc >= clr_from && cyc <= clr_to));
            chk("err",       int'(err),       int'(err_from >= 0 && cyc >= err_from));
            chk("dac_data",  int'(dac_data),  int'(data_cur));
            chk("owner",     int'(owner),     int'(owner_cur));

            if (rst) begin
                model_reset();
            end else if (pend && cyc >= start_cyc) begin
                if (rise_cyc < 0) begin
                    if (dac_busy) begin
                        rise_cyc = cyc;
                    end else if (cyc == start_cyc + BTO - 1) begin
                        if (err_from < 0) err_from = cyc + 1;
                        free_at = cyc + 1 + HOLD;
                        pend = 1'b0;
                    end
                end else if (!dac_busy) begin
                    free_at = cyc + 1 + HOLD;
                    pend = 1'b0;
                end
            end else if (!pend && cyc >= free_at) begin
                if (clr_req) begin
                    clr_from   = cyc + 1;
                    clr_to     = cyc + CLRC;
                    clr_ack_at = cyc + CLRC + 1;
                    free_at    = cyc + CLRC + 1 + HOLD;
                end else if (req0 || req1) begin
                    g = (req0 && req1) ? ~owner_latest : req1;
                    if (g) ack1_at = cyc + 1; else ack0_at = cyc + 1;
                    start_at     = cyc + 1;
                    data_pend    = g ? data1 : data0;
                    data_apply   = cyc + 1;
                    owner_pend   = g;
                    owner_apply  = cyc + 1;
                    owner_latest = g;
                    pend      = 1'b1;
                    start_cyc = cyc + 1;
                    rise_cyc  = -1;
                    free_at   = 32'h7fff_ffff;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic do_reset();
        step(); rst = 1'b1;
        step();
        step(); rst = 1'b0;
    endtask

    task automatic wait_grant(output int who, output int c);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_50M);
            if (ack0 || ack1) begin
                who = int'(ack1);
                c   = cyc;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_grant: no ack within 300 cycles (cycle %0d)", cyc);
        who = -1;
        c   = -1;
    endtask

    int r, a, a2, who, n_clr, c_ack, e, n_ack;

    initial begin
        repeat (3) step();
        rst = 1'b0;

        // Single request with normal busy profile, then holdoff-limited regrant.
        do_reset();
        busy_mode = 1'b1;
        step(); data0 = 12'hABC; req0 = 1'b1; r = cyc;
        wait_grant(who, a);
        chk("t35_who", who, 0);
        chk("t35_ack_latency", a, r + 1);
        chk("t35_data", int'(dac_data), 12'hABC);
        chk("t35_start", int'(dac_start), 1);
        wait_grant(who, a2);
        chk("t35_regrant_cycle", a2, a + 70);
        step(); req0 = 1'b0;

        // Both requesters held: alternating grants starting with requester 0.
        do_reset();
        step(); data0 = 12'h111; data1 = 12'h222; req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(who, a);
            chk("t36_order", who, k % 2);
            chk("t36_owner", int'(owner), k % 2);
            chk("t36_data", int'(dac_data), (k % 2) ? 12'h222 : 12'h111);
        end
        step(); req0 = 1'b0; req1 = 1'b0;

        // Clear beats a simultaneous sample request.
        do_reset();
        step(); clr_req = 1'b1; req1 = 1'b1; data1 = 12'h5A5; r = cyc;
        step(); clr_req = 1'b0;
        n_clr = 0; c_ack = -1;
        for (int i = 0; i < 20 && c_ack < 0; i++) begin
            @(negedge clk_50M);
            if (dac_clr) n_clr++;
            if (clr_ack) c_ack = cyc;
        end
        chk("t37_clr_len", n_clr, 4);
        chk("t37_clr_ack_cycle", c_ack, r + 5);
        chk("t37_data_kept", int'(dac_data), 0);
        wait_grant(who, a);
        chk("t37_who", who, 1);
        chk("t37_grant_cycle", a, r + 56);
        step(); req1 = 1'b0;

        // Serializer never goes busy: timeout, sticky err.
        do_reset();
        busy_mode = 1'b0;
        step(); data0 = 12'h0F0; req0 = 1'b1; r = cyc;
        wait_grant(who, a);
        chk("t38_ack_latency", a, r + 1);
        e = -1;
        for (int i = 0; i < 20 && e < 0; i++) begin
            @(negedge clk_50M);
            if (err) e = cyc;
        end
        chk("t38_err_cycle", e, a + 8);
        wait_grant(who, a2);
        chk("t38_regrant_cycle", a2, a + 59);
        step(); req0 = 1'b0;
        repeat (70) step();
        chk("t38_err_sticky", int'(err), 1);
        do_reset();
        @(negedge clk_50M);
        chk("t38_err_cleared", int'(err), 0);
        busy_mode = 1'b1;

        // Reset while the serializer is busy aborts without a late ack.
        do_reset();
        step(); data0 = 12'h321; req0 = 1'b1; r = cyc;
        wait_grant(who, a);
        chk("t39_ack_latency", a, r + 1);
        step(); req0 = 1'b0;
        while (cyc < a + 7) step();
        rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk_50M);
        chk("t39_owner_reset", int'(owner), 1);
        chk("t39_data_reset", int'(dac_data), 0);
        n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50M);
            if (ack0 || ack1 || clr_ack || dac_start) n_ack++;
        end
        chk("t39_no_pulses", n_ack, 0);
        step(); data0 = 12'h7E7; req0 = 1'b1; r = cyc;
        wait_grant(who, a);
        chk("t39_regrant_who", who, 0);
        chk("t39_regrant_latency", a, r + 1);
        chk("t39_regrant_data", int'(dac_data), 12'h7E7);
        step(); req0 = 1'b0;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
